alu_seq8: RTL and testbench
===========================

ALU_SEQ8 -- requirements
Module: alu_seq8

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 2: number of 4-bit slices; data width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request an operation; sampled each rising edge.
REQ-005 The block SHALL have port a  input  W  first operand; sampled only when start is accepted.
REQ-006 The block SHALL have port b  input  W  second operand; sampled only when start is accepted.
REQ-007 The block SHALL have port op  input  1  operation select: 0 = a+b, 1 = a-b; sampled only when start is accepted.
REQ-008 The block SHALL have port busy  output  1  operation in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking result and flags valid.
REQ-010 The block SHALL have port result  output  W  sum or difference.
REQ-011 The block SHALL have port carry  output  1  final carry out; for subtract, 1 = no borrow.
REQ-012 The block SHALL have port zero  output  1  result == 0.
REQ-013 The block SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-014 The block SHALL implement the states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-015 In IDLE or DONE, start=1 SHALL be accepted at that edge: latch a, b XOR {W{op}}, op as initial carry, slice index 0; go to RUN.
REQ-016 A start accepted at edge t SHALL cause the next NIBBLES edges (t+1..t+NIBBLES) to each add one 4-bit slice, LSB slice first: slice sum = a_slice + b'_slice + carry_reg; write result slice; update carry_reg.
REQ-017 The edge that computes the last slice SHALL move the state to DONE, set done=1 and update carry, zero and ovf.
REQ-018 done SHALL be high for exactly one cycle; from DONE the block SHALL go to IDLE unless start=1, in which case it goes to RUN (back-to-back, done still drops).
REQ-019 busy SHALL be 1 in RUN only: set at the accepting edge, cleared at the last-slice edge.
REQ-020 start while in RUN SHALL be ignored; latched operands SHALL be unaffected by a, b and op while busy.
REQ-021 Arithmetic SHALL be modulo 2^W; carry = carry out of bit W-1; ovf = (carry into bit W-1) XOR (carry out of bit W-1); zero = (result == 0).
REQ-022 Intermediate result slices MAY change during RUN; result and flags are defined only from done=1 onward.
REQ-023 result, carry, zero and ovf SHALL hold their values after done until the next operation's last-slice edge.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE and busy=0, done=0, result=0, carry=0, zero=0, ovf=0 and clear internal operand, carry and index registers.
REQ-025 rst SHALL take priority over start; reset during RUN SHALL abort the operation with no done pulse.
REQ-026 The first start SHALL be accepted on the first edge with rst=0.

Verification (NIBBLES=2)
REQ-027 Start a=0x43 b=0x35 op=0 -> busy 2 cycles, done 1 cycle, result=0x78 carry=0 zero=0 ovf=0.
REQ-028 Start a=0xFF b=0x01 op=0 -> result=0x00 carry=1 zero=1 ovf=0; then a=0x7F b=0x01 op=0 -> result=0x80 carry=0 ovf=1.
REQ-029 Start a=0x05 b=0x07 op=1 -> result=0xFE carry=0 ovf=0; then a=0x80 b=0x01 op=1 -> result=0x7F carry=1 ovf=1.
REQ-030 Start 0x12+0x34 op=0, drive start=1 with a=0xFF b=0xFF during busy -> request ignored, result=0x46; start held high in DONE -> new op accepted with no idle gap.
REQ-031 Start an op, assert rst on the edge after acceptance -> no done pulse, all outputs 0, state IDLE; next start completes normally.
REQ-032 Result-hold check: after done, toggle a, b and op with start=0 for 5 cycles -> result and flags unchanged, busy=0, done=0.

Source files
------------

// File: rtl/alu_seq8.sv
// Nibble-serial add/subtract unit: one 4-bit slice per clock, LSB slice first.
// Result and flags are registered and only change on the last-slice edge.
module alu_seq8 #(
  parameter int NIBBLES = 2,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         ovf
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, b_reg, acc_reg, acc_next;
  logic           carry_reg;
  logic [IW-1:0]  idx_reg;
  logic [3:0]     a_sl [NIBBLES];
  logic [3:0]     b_sl [NIBBLES];
  logic [3:0]     a_s, b_s, low;
  logic [4:0]     sum;
  logic           last;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_slice
      assign a_sl[gi] = a_reg[4*gi +: 4];
      assign b_sl[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  // low[3] is the carry into the slice MSB, needed for the overflow flag
  always_comb begin
    a_s  = a_sl[idx_reg];
    b_s  = b_sl[idx_reg];
    sum  = {1'b0, a_s} + {1'b0, b_s} + {4'b0, carry_reg};
    low  = {1'b0, a_s[2:0]} + {1'b0, b_s[2:0]} + {3'b0, carry_reg};
    last = (idx_reg == IW'(NIBBLES - 1));
    acc_next = acc_reg;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_reg == IW'(i)) acc_next[4*i +: 4] = sum[3:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (last) state_next = DONE;
      default: state_next = start ? RUN : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_reg == RUN) begin
        acc_reg   <= acc_next;
        carry_reg <= sum[4];
        idx_reg   <= idx_reg + 1'b1;
        if (last) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= acc_next;
          carry  <= sum[4];
          zero   <= (acc_next == '0);
          ovf    <= low[3] ^ sum[4];
        end
      end else if (start) begin
        // subtract is a + ~b + 1: invert b here and seed the carry with op
        a_reg     <= a;
        b_reg     <= b ^ {W{op}};
        carry_reg <= op;
        idx_reg   <= '0;
        busy      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq8.sv
// Directed and random checks of alu_seq8 (NIBBLES=2) against an arithmetic model.
module tb_alu_seq8;
  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk = 0, rst = 1, start = 0, op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic         busy, done, carry, zero, ovf;
  logic [W-1:0] result;
  int tests = 0, fails = 0;

  alu_seq8 #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] r, output logic c, output logic z, output logic v);
    int full;
    if (s) begin
      full = int'(x) - int'(y);
      c = (x >= y);
    end else begin
      full = int'(x) + int'(y);
      c = (full >= (1 << W));
    end
    r = full[W-1:0];
    z = (r == 0);
    if (s) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endtask

  // Called just after a negedge; start is accepted at the next posedge
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] er;
    logic ec, ez, ev;
    int k;
    model(x, y, s, er, ec, ez, ev);
    a = x; b = y; op = s; start = 1;
    @(negedge clk);
    start = 0; a = ~x; b = ~y; op = ~s;
    chk("busy_after_accept", busy, 1);
    chk("done_after_accept", done, 0);
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("latency", k, N);
    chk("result", result, er);
    chk("carry", carry, ec);
    chk("zero", zero, ez);
    chk("ovf", ovf, ev);
    chk("busy_at_done", busy, 0);
    $display("[TB] op=%0d a=%02h b=%02h -> result=%02h c=%0d z=%0d v=%0d", s, x, y, result, carry, zero, ovf);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    logic [W-1:0] hold_r;
    logic [3:0]   hold_f;
    int k;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, zero, ovf}, 0);

    rst = 0;  // first start on the very first edge without reset
    do_op(8'h43, 8'h35, 0);
    do_op(8'hFF, 8'h01, 0);
    do_op(8'h7F, 8'h01, 0);
    do_op(8'h05, 8'h07, 1);
    do_op(8'h80, 8'h01, 1);

    // start during busy ignored; start held into DONE goes back to back
    a = 8'h12; b = 8'h34; op = 0; start = 1;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; op = 0;
    chk("b2b_busy1", busy, 1);
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("b2b_latency1", k, N);
    chk("b2b_result1", result, 8'h46);
    $display("[TB] op=0 a=12 b=34 -> result=%02h (start held)", result);
    @(negedge clk);
    start = 0;
    chk("b2b_no_gap", busy, 1);
    chk("b2b_done_drop", done, 0);
    chk("b2b_hold", result, 8'h46);
    for (k = 1; k <= 10; k++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("b2b_result2", result, 8'hFE);
    chk("b2b_carry2", carry, 1);
    $display("[TB] op=0 a=ff b=ff -> result=%02h c=%0d", result, carry);
    @(negedge clk);

    // reset on the edge after acceptance aborts the operation
    a = 8'h11; b = 8'h22; op = 0; start = 1;
    @(negedge clk);
    start = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {carry, zero, ovf}, 0);
    for (k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 0);
    end
    $display("[TB] aborted op a=11 b=22 by reset");
    do_op(8'h11, 8'h22, 0);

    // outputs hold while inputs toggle with start low
    hold_r = result;
    hold_f = {1'b0, carry, zero, ovf};
    for (k = 0; k < 5; k++) begin
      a = 8'($urandom); b = 8'($urandom); op = ~op;
      @(negedge clk);
      chk("hold_result", result, hold_r);
      chk("hold_flags", {1'b0, carry, zero, ovf}, hold_f);
      chk("hold_ctrl", {busy, done}, 0);
    end
    $display("[TB] hold check result=%02h", result);

    for (int i = 0; i < 24; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
